// File: rtl/uart_program_loader.sv
// uart_program_loader: parses a SYNC/LEN/data/CHK frame from the UART, checks it,
// then bursts it into the CPU RAM while holding the CPU in reset.
module uart_program_loader #(
    parameter int          DEPTH      = 16,
    parameter int          ADDR_WIDTH = 4,
    parameter logic [7:0]  SYNC_BYTE  = 8'hA5,
    parameter int          TIMEOUT    = 1200000
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [7:0]            wr_data,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  load_done,
    output logic                  load_err,
    output logic [1:0]            err_code
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, LEN, DATA, CSUM, COMMIT, ERROR} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d, last_q, last_d;
    logic [7:0]            sum_q, sum_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [7:0]            mem_q [DEPTH];
    logic                  wr_en_d, done_d, err_d;
    logic [ADDR_WIDTH-1:0] wr_addr_d;
    logic [7:0]            wr_data_d;
    logic [1:0]            code_d;
    logic                  in_frame;

    assign in_frame = (state_q == LEN) || (state_q == DATA) || (state_q == CSUM);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        last_d    = last_q;
        sum_d     = sum_q;
        cnt_d     = '0;
        wr_en_d   = 1'b0;
        wr_addr_d = '0;
        wr_data_d = '0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        code_d    = err_code;
        case (state_q)
            IDLE: if (rx_valid && rx_data == SYNC_BYTE) begin
                state_d = LEN;
                code_d  = 2'd0;
            end
            LEN: if (rx_valid) begin
                if (rx_data == 8'd0 || rx_data > 8'(DEPTH)) begin
                    state_d = ERROR;
                    err_d   = 1'b1;
                    code_d  = 2'd1;
                end else begin
                    state_d = DATA;
                    last_d  = ADDR_WIDTH'(rx_data - 8'd1);
                    idx_d   = '0;
                    sum_d   = '0;
                end
            end
            DATA: if (rx_valid) begin
                sum_d   = sum_q + rx_data;
                idx_d   = idx_q + 1'b1;
                state_d = (idx_q == last_q) ? CSUM : DATA;
            end
            CSUM: if (rx_valid) begin
                if (rx_data == sum_q) begin
                    state_d   = COMMIT;
                    idx_d     = '0;
                    wr_en_d   = 1'b1;
                    wr_data_d = mem_q[0];
                end else begin
                    state_d = ERROR;
                    err_d   = 1'b1;
                    code_d  = 2'd2;
                end
            end
            COMMIT: if (idx_q == last_q) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end else begin
                idx_d     = idx_q + 1'b1;
                wr_en_d   = 1'b1;
                wr_addr_d = idx_d;
                wr_data_d = mem_q[idx_d];
            end
            default: state_d = IDLE;
        endcase
        // A byte arriving on the expiry cycle wins over the timeout.
        if (in_frame) begin
            cnt_d = rx_valid ? '0 : cnt_q + 1'b1;
            if (!rx_valid && cnt_q == CW'(TIMEOUT)) begin
                state_d = ERROR;
                err_d   = 1'b1;
                code_d  = 2'd3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            last_q    <= '0;
            sum_q     <= '0;
            cnt_q     <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            cpu_hold  <= 1'b0;
            busy      <= 1'b0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
            err_code  <= 2'd0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            last_q    <= last_d;
            sum_q     <= sum_d;
            cnt_q     <= cnt_d;
            wr_en     <= wr_en_d;
            wr_addr   <= wr_addr_d;
            wr_data   <= wr_data_d;
            cpu_hold  <= (state_d != IDLE) && (state_d != ERROR);
            busy      <= state_d != IDLE;
            load_done <= done_d;
            load_err  <= err_d;
            err_code  <= code_d;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == DATA && rx_valid) mem_q[idx_q] <= rx_data;
    end
endmodule

// File: tb/tb_uart_program_loader.sv
// tb_uart_program_loader: per-cycle vector table plus hand sequences for the
// 16-byte burst, timeout boundary and reset mid-commit.
module tb_uart_program_loader;
    logic       clk = 1'b0, clr, rx_valid;
    logic [7:0] rx_data, wr_data;
    logic [3:0] wr_addr;
    logic       wr_en, cpu_hold, busy, load_done, load_err;
    logic [1:0] err_code;
    int         n_vec = 0, n_bad = 0;

    always #5 clk = ~clk;

    uart_program_loader #(.TIMEOUT(50)) dut (
        .clk(clk), .clr(clr), .rx_data(rx_data), .rx_valid(rx_valid),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .cpu_hold(cpu_hold),
        .busy(busy), .load_done(load_done), .load_err(load_err), .err_code(err_code)
    );

    typedef struct {
        string       name;
        logic        c;
        logic        v;
        logic [7:0]  d;
        logic [18:0] e;
    } vec_t;

    vec_t tbl[$];

    // expected output word: {wr_en, wr_addr, wr_data, cpu_hold, busy, load_done, load_err, err_code}
    function automatic logic [18:0] ex(input logic we, input logic [3:0] a, input logic [7:0] wd,
                                       input logic h, input logic b, input logic dn,
                                       input logic er, input logic [1:0] ec);
        return {we, a, wd, h, b, dn, er, ec};
    endfunction

    function automatic logic [18:0] wrv(input logic [3:0] a, input logic [7:0] wd);
        return ex(1'b1, a, wd, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
    endfunction

    function automatic logic [18:0] errv(input logic [1:0] ec);
        return ex(1'b0, 4'h0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, ec);
    endfunction

    function automatic logic [18:0] idc(input logic [1:0] ec);
        return ex(1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, ec);
    endfunction

    logic [18:0] IDL, HOLD, DONE;

    task automatic add(input string n, input logic c, input logic v, input logic [7:0] d,
                       input logic [18:0] e);
        vec_t r;
        r = '{n, c, v, d, e};
        tbl.push_back(r);
    endtask

    task automatic cyc(input logic c, input logic v, input logic [7:0] d);
        clr = c;
        rx_valid = v;
        rx_data = d;
        @(negedge clk);
    endtask

    task automatic chk(input string n, input logic [18:0] e);
        logic [18:0] a;
        a = {wr_en, wr_addr, wr_data, cpu_hold, busy, load_done, load_err, err_code};
        n_vec++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got we=%b a=%h d=%h hold=%b busy=%b done=%b err=%b code=%0d, expected we=%b a=%h d=%h hold=%b busy=%b done=%b err=%b code=%0d",
                     n, a[18], a[17:14], a[13:6], a[5], a[4], a[3], a[2], a[1:0],
                     e[18], e[17:14], e[13:6], e[5], e[4], e[3], e[2], e[1:0]);
        end
    endtask

    task automatic run(input string n, input logic c, input logic v, input logic [7:0] d,
                       input logic [18:0] e);
        cyc(c, v, d);
        chk(n, e);
    endtask

    task automatic frame16(input string n);
        run({n, "_sync"}, 1'b0, 1'b1, 8'hA5, HOLD);
        run({n, "_len"}, 1'b0, 1'b1, 8'h10, HOLD);
        for (int i = 0; i < 16; i++) run({n, "_data"}, 1'b0, 1'b1, 8'(i), HOLD);
        run({n, "_chk_w0"}, 1'b0, 1'b1, 8'h78, wrv(4'h0, 8'h00));
    endtask

    initial begin
        IDL  = idc(2'd0);
        HOLD = ex(1'b0, 4'h0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
        DONE = ex(1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
        clr = 1'b1;
        rx_valid = 1'b0;
        rx_data = 8'h00;
        @(negedge clk);

        add("reset0", 1, 0, 8'h00, IDL);
        add("reset1", 1, 1, 8'hA5, IDL);
        add("idle_novalid_a5", 0, 0, 8'hA5, IDL);
        add("good_sync", 0, 1, 8'hA5, HOLD);
        add("good_len", 0, 1, 8'h03, HOLD);
        add("good_d0", 0, 1, 8'h1E, HOLD);
        add("good_d1", 0, 1, 8'h2F, HOLD);
        add("good_d2", 0, 1, 8'hE0, HOLD);
        add("good_w0", 0, 1, 8'h2D, wrv(4'h0, 8'h1E));
        add("good_w1", 0, 0, 8'h00, wrv(4'h1, 8'h2F));
        add("good_w2", 0, 0, 8'h00, wrv(4'h2, 8'hE0));
        add("good_done", 0, 0, 8'h00, DONE);
        add("good_idle", 0, 0, 8'h00, IDL);
        add("bchk_sync", 0, 1, 8'hA5, HOLD);
        add("bchk_len", 0, 1, 8'h02, HOLD);
        add("bchk_d0", 0, 1, 8'h10, HOLD);
        add("bchk_d1", 0, 1, 8'h20, HOLD);
        add("bchk_err", 0, 1, 8'h31, errv(2'd2));
        add("bchk_hold", 0, 0, 8'h00, idc(2'd2));
        add("bchk_junk", 0, 1, 8'h30, idc(2'd2));
        add("blen0_sync", 0, 1, 8'hA5, HOLD);
        add("blen0_err", 0, 1, 8'h00, errv(2'd1));
        add("blen0_hold", 0, 0, 8'h00, idc(2'd1));
        add("blen17_sync", 0, 1, 8'hA5, HOLD);
        add("blen17_err", 0, 1, 8'h11, errv(2'd1));
        add("blen17_hold", 0, 0, 8'h00, idc(2'd1));
        add("one_sync", 0, 1, 8'hA5, HOLD);
        add("one_len", 0, 1, 8'h01, HOLD);
        add("one_d0", 0, 1, 8'h07, HOLD);
        add("one_w0", 0, 1, 8'h07, wrv(4'h0, 8'h07));
        add("one_done", 0, 0, 8'h00, DONE);
        add("one_idle", 0, 0, 8'h00, IDL);
        add("a5d_sync", 0, 1, 8'hA5, HOLD);
        add("a5d_len", 0, 1, 8'h02, HOLD);
        add("a5d_d0", 0, 1, 8'hA5, HOLD);
        add("a5d_d1", 0, 1, 8'h01, HOLD);
        add("a5d_w0", 0, 1, 8'hA6, wrv(4'h0, 8'hA5));
        add("a5d_w1_rx_ignored", 0, 1, 8'hA5, wrv(4'h1, 8'h01));
        add("a5d_done", 0, 0, 8'h00, DONE);
        add("a5d_idle", 0, 0, 8'h00, IDL);
        add("junk_00", 0, 1, 8'h00, IDL);
        add("junk_ff", 0, 1, 8'hFF, IDL);

        foreach (tbl[i]) run(tbl[i].name, tbl[i].c, tbl[i].v, tbl[i].d, tbl[i].e);

        frame16("full");
        for (int k = 1; k < 16; k++) run("full_w", 1'b0, 1'b0, 8'h00, wrv(4'(k), 8'(k)));
        run("full_done", 1'b0, 1'b0, 8'h00, DONE);
        run("full_idle", 1'b0, 1'b0, 8'h00, IDL);

        run("to_sync", 1'b0, 1'b1, 8'hA5, HOLD);
        run("to_len", 1'b0, 1'b1, 8'h02, HOLD);
        run("to_d0", 1'b0, 1'b1, 8'h10, HOLD);
        for (int k = 1; k <= 50; k++) run("to_wait", 1'b0, 1'b0, 8'h00, HOLD);
        run("to_err_at_51", 1'b0, 1'b0, 8'h00, errv(2'd3));
        run("to_hold", 1'b0, 1'b0, 8'h00, idc(2'd3));

        run("win_sync", 1'b0, 1'b1, 8'hA5, HOLD);
        run("win_len", 1'b0, 1'b1, 8'h02, HOLD);
        run("win_d0", 1'b0, 1'b1, 8'h10, HOLD);
        for (int k = 1; k <= 50; k++) run("win_wait", 1'b0, 1'b0, 8'h00, HOLD);
        run("win_byte_at_expiry", 1'b0, 1'b1, 8'h20, HOLD);
        run("win_w0", 1'b0, 1'b1, 8'h30, wrv(4'h0, 8'h10));
        run("win_w1", 1'b0, 1'b0, 8'h00, wrv(4'h1, 8'h20));
        run("win_done", 1'b0, 1'b0, 8'h00, DONE);

        frame16("rst");
        run("rst_w1", 1'b0, 1'b0, 8'h00, wrv(4'h1, 8'h01));
        run("rst_clr", 1'b1, 1'b0, 8'h00, IDL);
        for (int k = 0; k < 20; k++) run("rst_after", 1'b0, 1'b0, 8'h00, IDL);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_program_loader.md
Name: uart_program_loader

Overview:
- Sits directly upstream of the CPU's 16x8 RAM. Consumes received bytes from uart_receive, parses one program frame, and buffers it internally.
- Verifies the frame's checksum, then bursts the program into RAM through a write port muxed with the CPU path in top.
- Holds the CPU in reset (cpu_hold) for the whole load. On any error it aborts without touching RAM.

Parameters:
- DEPTH, 16: max program bytes; equals RAM size.
- ADDR_WIDTH, 4: RAM address width.
- SYNC_BYTE, 8'hA5: frame start marker.
- TIMEOUT, 1200000: max clk cycles allowed between bytes inside a frame (0.1 s at 12 MHz).

Ports:
- clk  input  1  system clock
- clr  input  1  synchronous active-high reset
- rx_data  input  8  received byte; valid only when rx_valid=1
- rx_valid  input  1  one-cycle strobe per received byte; may be high on consecutive cycles
- wr_en  output  1  RAM write enable
- wr_addr  output  4  RAM write address
- wr_data  output  8  RAM write data
- cpu_hold  output  1  1 = CPU held in reset; top ORs it into CPU clr
- busy  output  1  1 whenever state != IDLE
- load_done  output  1  one-cycle pulse: frame committed
- load_err  output  1  one-cycle pulse: frame rejected
- err_code  output  2  0 none, 1 bad length, 2 bad checksum, 3 timeout

Behaviour:
- Reset (clr=1 at posedge):
  - state=IDLE.
  - All outputs 0, err_code=0.
  - Buffer contents don't-care.
- Frame format: SYNC_BYTE, LEN, LEN data bytes, CHK. CHK = sum of data bytes mod 256.
- All state is registered; outputs are driven from registers.
- IDLE:
  - rx_valid with rx_data==SYNC_BYTE -> LEN state. cpu_hold=1 and busy=1 from the next cycle.
  - err_code is cleared to 0 at this point.
  - All other bytes are ignored.
- LEN state, on rx_valid:
  - LEN in 1..DEPTH: store len, idx=0, sum=0 -> DATA.
  - LEN of 0 or >DEPTH -> ERROR with code 1.
- DATA state, on rx_valid:
  - buf[idx]=rx_data; sum=sum+rx_data, truncated to 8 bits; idx++.
  - When the byte just stored is the one at idx==len-1 -> CSUM.
  - A byte equal to SYNC_BYTE is treated as ordinary data; there is no resync.
- CSUM state, on rx_valid:
  - rx_data==sum -> COMMIT.
  - Otherwise -> ERROR with code 2.
- Timeout:
  - In LEN, DATA and CSUM a cycle counter is zeroed on entry and on every rx_valid.
  - If it reaches TIMEOUT with no byte -> ERROR with code 3.
- COMMIT:
  - First wr_en occurs the cycle after CHK is sampled.
  - wr_en=1 for exactly len consecutive cycles; cycle k drives wr_addr=k, wr_data=buf[k].
  - Addresses len..DEPTH-1 are not written.
  - rx_valid is ignored during COMMIT.
  - The cycle after the last write: wr_en=0, load_done=1 for 1 cycle, cpu_hold=0, busy=0, -> IDLE.
- ERROR:
  - Entered the cycle after the offending byte or timeout.
  - load_err=1 for 1 cycle; err_code is latched and holds until the next SYNC in IDLE or reset.
  - cpu_hold=0; no wr_en ever asserted for that frame; -> IDLE next cycle.
- wr_addr and wr_data are 0 whenever wr_en=0.
- clr mid-operation (including mid-COMMIT):
  - The next cycle sees wr_en=0, cpu_hold=0, no done/err pulse, state IDLE.
  - A partial RAM write is acceptable.
- rx_valid arriving in the same cycle as a timeout expiry: the byte wins and the counter clears.

Test Plan:
1. Good frame: A5 03 1E 2F E0 2D -> 3 consecutive wr_en cycles writing (0,1E),(1,2F),(2,E0); then load_done pulse; cpu_hold high from the cycle after A5 until the load_done cycle.
2. Bad checksum: A5 02 10 20 31 -> load_err pulse, err_code=2, wr_en never high, cpu_hold back to 0.
3. Bad length: A5 00 -> err_code=1; then A5 11 -> err_code=1; then a valid frame A5 01 07 07 -> err_code cleared to 0 and write (0,07).
4. Timeout (TIMEOUT=50): A5 02 10 then idle -> load_err exactly 51 cycles after the 10 strobe, err_code=3, no writes.
5. Full program with junk prefix: 00 FF A5 10 00..0F 78 -> prefix ignored; 16 back-to-back writes, addr n = data n; load_done; data byte A5 inside a frame is accepted as data.
6. Reset mid-commit: good 16-byte frame, clr asserted after the 2nd write -> wr_en=0 and cpu_hold=0 the next cycle, no load_done, busy=0.
